sv_stream_reader: RTL and testbench

- Read-side sequencer for the support-vector output memory.
- After training completes, it walks the stored support vectors (alpha, x, y) from address 0 up to the stored count minus 1, issuing synchronous reads.
- It streams each entry to the classifier datapath over a valid/ready interface, with a 2-entry skid buffer that absorbs the memory's one-cycle read latency under backpressure.
- It is the consumer counterpart of the trainer-to-memory write path.

---
 rtl/sv_stream_reader.sv | 141 ++++++++++++++
 tb/tb_sv_stream_reader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sv_stream_reader.sv
// Read-side sequencer for the support-vector memory: walks addresses 0..N-1 and
// streams (alpha, x, y) downstream through a 2-entry skid buffer over valid/ready.
module sv_stream_reader #(
  parameter int AW = 7,
  parameter int DW = 9,
  parameter int YW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] sv_count,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_alpha,
  input  logic [DW-1:0] rd_xsv,
  input  logic [YW-1:0] rd_ysv,
  output logic          sv_valid,
  input  logic          sv_ready,
  output logic [DW-1:0] sv_alpha,
  output logic [DW-1:0] sv_xsv,
  output logic [YW-1:0] sv_ysv,
  output logic          sv_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_FINISH} state_t;

  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t                state, state_nxt;
  logic [AW-1:0]         count_q;
  logic [AW-1:0]         addr_p0;
  logic                  vld_p1;
  logic                  last_p1;
  logic [1:0]            occ;
  logic [DW-1:0]         alpha_buf [2];
  logic [DW-1:0]         xsv_buf   [2];
  logic signed [YW-1:0]  ysv_buf   [2];
  logic                  last_buf  [2];

  logic [1:0]            pending;
  logic                  issue;
  logic                  is_last_addr;
  logic                  head_vld;
  logic                  head_last;
  logic [DW-1:0]         head_alpha;
  logic [DW-1:0]         head_xsv;
  logic signed [YW-1:0]  head_ysv;
  logic                  pop;
  logic                  pop_buf;
  logic                  wr_buf;
  logic                  wr_slot;

  assign pending      = occ + {1'b0, vld_p1};
  assign is_last_addr = (addr_p0 == (count_q - ADDR_ONE));
  assign issue        = (state == S_FETCH) && (pending < 2'd2);

  // The arriving read word sits logically behind the buffered entries, so an
  // empty buffer lets it through in its arrival cycle.
  assign head_vld = (occ != 2'd0) || vld_p1;

  always_comb begin
    head_alpha = rd_alpha;
    head_xsv   = rd_xsv;
    head_ysv   = $signed(rd_ysv);
    head_last  = last_p1;
    if (occ != 2'd0) begin
      head_alpha = alpha_buf[0];
      head_xsv   = xsv_buf[0];
      head_ysv   = ysv_buf[0];
      head_last  = last_buf[0];
    end
  end

  assign pop     = head_vld && sv_ready;
  assign pop_buf = pop && (occ != 2'd0);
  assign wr_buf  = vld_p1 && !(pop && (occ == 2'd0));
  assign wr_slot = (occ == 2'd1) && !pop_buf;

  assign rd_en    = issue;
  assign rd_addr  = addr_p0;
  assign sv_valid = head_vld;
  assign sv_alpha = head_vld ? head_alpha : '0;
  assign sv_xsv   = head_vld ? head_xsv   : '0;
  assign sv_ysv   = head_vld ? head_ysv   : '0;
  assign sv_last  = head_vld && head_last;
  assign busy     = (state == S_FETCH) || (state == S_DRAIN);
  assign done     = (state == S_FINISH);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = (sv_count != '0) ? S_FETCH : S_FINISH;
      S_FETCH:  if (issue && is_last_addr) state_nxt = S_DRAIN;
      S_DRAIN:  if (pop && head_last && (pending == 2'd1)) state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Stage p0 -> p1: address issue and memory read in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      count_q <= '0;
      addr_p0 <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      occ     <= 2'd0;
    end else begin
      state   <= state_nxt;
      vld_p1  <= issue;
      last_p1 <= issue && is_last_addr;
      if ((state == S_IDLE) && start) begin
        count_q <= sv_count;
        addr_p0 <= '0;
      end else if (issue) begin
        addr_p0 <= addr_p0 + ADDR_ONE;
      end
      occ <= occ + {1'b0, wr_buf} - {1'b0, pop_buf};
    end
  end

  // Stage p1 -> buffer: read data lands in the skid slots, head at slot 0
  always_ff @(posedge clk) begin
    if (pop_buf) begin
      alpha_buf[0] <= alpha_buf[1];
      xsv_buf[0]   <= xsv_buf[1];
      ysv_buf[0]   <= ysv_buf[1];
      last_buf[0]  <= last_buf[1];
    end
    if (wr_buf) begin
      alpha_buf[wr_slot] <= rd_alpha;
      xsv_buf[wr_slot]   <= rd_xsv;
      ysv_buf[wr_slot]   <= $signed(rd_ysv);
      last_buf[wr_slot]  <= last_p1;
    end
  end

endmodule

// File: tb/tb_sv_stream_reader.sv
// Scoreboard bench for sv_stream_reader: a behavioural memory plus a pass-level
// reference queue; a negedge monitor checks every handshake, read and status bit.
module tb_sv_stream_reader;
  localparam int AW = 7;
  localparam int DW = 9;
  localparam int YW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] sv_count;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_alpha;
  logic [DW-1:0] rd_xsv;
  logic [YW-1:0] rd_ysv;
  logic          sv_valid;
  logic          sv_ready;
  logic [DW-1:0] sv_alpha;
  logic [DW-1:0] sv_xsv;
  logic [YW-1:0] sv_ysv;
  logic          sv_last;
  logic          busy;
  logic          done;

  sv_stream_reader #(.AW(AW), .DW(DW), .YW(YW)) dut (
    .clk(clk), .reset(reset), .start(start), .sv_count(sv_count),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_alpha(rd_alpha), .rd_xsv(rd_xsv),
    .rd_ysv(rd_ysv), .sv_valid(sv_valid), .sv_ready(sv_ready),
    .sv_alpha(sv_alpha), .sv_xsv(sv_xsv), .sv_ysv(sv_ysv), .sv_last(sv_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem_a [128];
  logic [DW-1:0] mem_x [128];
  logic [YW-1:0] mem_y [128];

  always @(posedge clk) begin
    if (rd_en) begin
      rd_alpha <= mem_a[rd_addr];
      rd_xsv   <= mem_x[rd_addr];
      rd_ysv   <= mem_y[rd_addr];
    end
  end

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] x;
    logic [YW-1:0] y;
    logic          last;
  } item_t;

  item_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Ready pattern generator
  int ready_mode = 0;
  int cyc = 0;
  int mark = 0;
  initial begin
    sv_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: sv_ready = 1'b1;
        1: sv_ready = (((cyc - mark) % 4) == 0) || (((cyc - mark) % 4) == 3);
        2: sv_ready = 1'($urandom_range(0, 1));
        3: sv_ready = ((cyc - mark) >= 12);
        default: sv_ready = 1'b0;
      endcase
      cyc++;
    end
  end

  // Reference model and monitor
  initial begin
    bit    active, exp_done, next_done, prev_stall, was_active;
    int    issued, accepted, exp_addr, pass_n;
    item_t cur, e, prev_item;
    active = 0; exp_done = 0; prev_stall = 0;
    issued = 0; accepted = 0; exp_addr = 0; pass_n = 0;
    prev_item = '0;
    forever begin
      @(negedge clk);
      cur = {sv_alpha, sv_xsv, sv_ysv, sv_last};
      if (reset) begin
        chk({rd_en, rd_addr, sv_valid, cur, busy, done} == '0, "reset_outputs",
            64'({rd_en, rd_addr, sv_valid, cur, busy, done}), 64'(0));
        exp_q.delete();
        active = 0; exp_done = 0; prev_stall = 0;
        issued = 0; accepted = 0; exp_addr = 0;
      end else begin
        next_done = 0;
        chk(done == exp_done, "done", 64'(done), 64'(exp_done));
        chk(busy == (active && !exp_done), "busy", 64'(busy), 64'(active && !exp_done));
        if (rd_en) begin
          chk((issued - accepted) < 2, "issue_rule", 64'(issued - accepted), 64'(1));
          chk(active && !exp_done && (exp_addr < pass_n) && (int'(rd_addr) == exp_addr),
              "rd_addr", 64'(rd_addr), 64'(exp_addr));
          issued++;
          exp_addr++;
        end
        if (prev_stall)
          chk(sv_valid && (cur == prev_item), "stall_hold", 64'(cur), 64'(prev_item));
        if (sv_valid) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_valid", 64'(cur), 64'(0));
          end else if (sv_ready) begin
            e = exp_q.pop_front();
            chk(cur == e, "entry", 64'(cur), 64'(e));
            accepted++;
            if (e.last) next_done = 1;
          end
        end
        prev_stall = sv_valid && !sv_ready;
        prev_item  = cur;
        was_active = active;
        if (exp_done) active = 0;
        if (start && !was_active) begin
          pass_n = int'(sv_count);
          exp_addr = 0; issued = 0; accepted = 0;
          for (int i = 0; i < pass_n; i++)
            exp_q.push_back({mem_a[i], mem_x[i], mem_y[i], (i == pass_n - 1)});
          active = 1;
          if (pass_n == 0) next_done = 1;
        end
        exp_done = next_done;
      end
    end
  end

  task automatic fill_random();
    for (int i = 0; i < 128; i++) begin
      mem_a[i] = DW'($urandom);
      mem_x[i] = DW'($urandom);
      mem_y[i] = YW'($urandom);
    end
  endtask

  task automatic pulse_start(input int n);
    @(posedge clk);
    #1;
    start = 1'b1;
    sv_count = AW'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    bit got;
    got = 0;
    lat = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (done) got = 1;
    end
    if (!got) chk(1'b0, "done_timeout", 64'(lat), 64'(0));
  endtask

  task automatic drain_check(input string name);
    repeat (4) @(negedge clk);
    chk(exp_q.size() == 0, name, 64'(exp_q.size()), 64'(0));
  endtask

  int lat;
  initial begin
    reset = 1'b1; start = 1'b0; sv_count = '0;
    fill_random();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk(!sv_valid && !busy && !done && !rd_en, "post_reset",
        64'({sv_valid, busy, done, rd_en}), 64'(0));

    // Known pattern, full throughput
    for (int i = 0; i < 128; i++) begin
      mem_a[i] = DW'(i + 1);
      mem_x[i] = DW'(i * 3);
      mem_y[i] = (i % 2 == 1) ? 2'b11 : 2'b01;
    end
    ready_mode = 0;
    pulse_start(4);
    wait_done(lat);
    chk(lat == 6, "lat_n4", 64'(lat), 64'(6));
    drain_check("drain_n4");

    // Periodic backpressure
    fill_random();
    mark = cyc; ready_mode = 1;
    pulse_start(5);
    wait_done(lat);
    drain_check("drain_n5");

    // Empty pass
    ready_mode = 0;
    pulse_start(0);
    wait_done(lat);
    chk(lat == 1, "lat_n0", 64'(lat), 64'(1));
    drain_check("drain_n0");

    // Single entry held under long stall
    fill_random();
    mark = cyc; ready_mode = 3;
    pulse_start(1);
    wait_done(lat);
    drain_check("drain_n1");

    // Restart and count change mid-pass are ignored
    fill_random();
    mark = cyc; ready_mode = 1;
    pulse_start(6);
    repeat (3) @(posedge clk);
    pulse_start(2);
    wait_done(lat);
    drain_check("drain_n6");

    // Reset while draining with a full buffer
    fill_random();
    ready_mode = 4;
    pulse_start(2);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    ready_mode = 0;
    pulse_start(3);
    wait_done(lat);
    chk(lat == 5, "lat_after_reset", 64'(lat), 64'(5));
    drain_check("drain_after_reset");

    // Random passes, including the maximum count
    for (int p = 0; p < 6; p++) begin
      fill_random();
      ready_mode = 2;
      pulse_start((p == 0) ? 127 : int'($urandom_range(1, 127)));
      wait_done(lat);
      drain_check("drain_random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
